// File: rtl/spi_pkg.sv
// spi_pkg
// Shared types and constants for the SPI mode-0 controller.
//   spi_state_t : controller FSM states
//   SPI_CPOL    : SCK idle level (0 = idles low)
//   SPI_CPHA    : sample phase (0 = sample on the leading SCK edge)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT_LO,
    SHIFT_HI,
    WAIT,
    TRAIL,
    GAP
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if
// Word-level valid/ready interface between a host and spi_controller.
//   tx_valid_i / tx_last_i / data_tx_i : word offered by the host
//   tx_ready_o                         : controller takes the word this cycle
//   data_rx_o / rx_valid_o             : received word and its one-cycle strobe
//   busy_o                             : controller is not idle
// Modports: master = host side, slave = controller side.
interface spi_controller_if #(
  parameter int WORD_SIZE = 8
) ();

  logic                 tx_valid_i;
  logic                 tx_last_i;
  logic [WORD_SIZE-1:0] data_tx_i;
  logic                 tx_ready_o;
  logic [WORD_SIZE-1:0] data_rx_o;
  logic                 rx_valid_o;
  logic                 busy_o;

  modport master (
    output tx_valid_i, tx_last_i, data_tx_i,
    input  tx_ready_o, data_rx_o, rx_valid_o, busy_o
  );

  modport slave (
    input  tx_valid_i, tx_last_i, data_tx_i,
    output tx_ready_o, data_rx_o, rx_valid_o, busy_o
  );

endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div
// Half-period tick generator for the SPI clock.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   clear_i : restart the count (used on every FSM state change)
//   tick_o  : high during the last cycle of a CLK_DIV-cycle phase
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int               CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]    TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count cycles within the current phase; a clear restarts the phase so
  // that every FSM state lasts exactly CLK_DIV cycles from its entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/spi_controller.sv
// spi_controller
// SPI mode-0 master (CPOL=0, CPHA=0) with a valid/ready word interface.
// Chip select is held low across a burst until a word flagged last ends.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   bus          : word interface (slave modport)
//   sck_o        : SPI clock, idles low
//   cs_o         : chip select, active low
//   sdo_o        : MOSI, MSB first, 0 while cs_o is high
//   sdi_i        : MISO, sampled on the clk_i edge that raises sck_o
module spi_controller
  import spi_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_controller_if.slave  bus,
  output logic             sck_o,
  output logic             cs_o,
  output logic             sdo_o,
  input  logic             sdi_i
);

  localparam int            BW       = $clog2(WORD_SIZE) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE);

  if (WORD_SIZE < 2) begin : g_bad_word_size
    $error("spi_controller: WORD_SIZE must be at least 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be at least 2");
  end
  if (SPI_CPOL != 1'b0 || SPI_CPHA != 1'b0) begin : g_bad_mode
    $error("spi_controller: only SPI mode 0 is implemented");
  end

  spi_state_t           state_q, state_d;
  logic                 tick;
  logic                 phase_clear;
  logic                 tx_ready;
  logic                 busy;
  logic                 accept;
  logic                 word_done;
  logic                 rise_evt;
  logic                 fall_evt;
  logic                 end_evt;
  logic [WORD_SIZE-1:0] tx_shift_q;
  logic [WORD_SIZE-1:0] rx_shift_q;
  logic [WORD_SIZE-1:0] data_rx_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 last_q;
  logic                 rx_valid_q;

  // Every state change restarts the phase counter.
  assign phase_clear = (state_d != state_q);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (phase_clear),
    .tick_o  (tick)
  );

  assign accept    = bus.tx_valid_i && tx_ready;
  assign word_done = (bit_cnt_q == LAST_BIT);
  // A rising SCK edge starts from LEAD or from a low phase with bits left.
  assign rise_evt  = tick && ((state_q == LEAD) || (state_q == SHIFT_LO && !word_done));
  assign fall_evt  = tick && (state_q == SHIFT_HI);
  // The word closes at the end of the low phase following the final bit.
  assign end_evt   = tick && (state_q == SHIFT_LO) && word_done;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: phases advance only on a divider tick; IDLE and WAIT
  // move only on an accepted word, so WAIT can stall indefinitely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = LEAD;
      LEAD:     if (tick)   state_d = SHIFT_HI;
      SHIFT_HI: if (tick)   state_d = SHIFT_LO;
      SHIFT_LO: begin
        if (tick) begin
          if (!word_done)  state_d = SHIFT_HI;
          else if (last_q) state_d = TRAIL;
          else             state_d = WAIT;
        end
      end
      WAIT:     if (accept) state_d = SHIFT_LO;
      TRAIL:    if (tick)   state_d = GAP;
      GAP:      if (tick)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output decode from the registered state, so pins change only on clk_i.
  always_comb begin
    cs_o     = 1'b1;
    sck_o    = SPI_CPOL;
    tx_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      LEAD, SHIFT_LO, TRAIL: begin
        cs_o = 1'b0;
      end
      SHIFT_HI: begin
        cs_o  = 1'b0;
        sck_o = ~SPI_CPOL;
      end
      WAIT: begin
        cs_o     = 1'b0;
        tx_ready = 1'b1;
      end
      default: begin
        cs_o = 1'b1;
      end
    endcase
    if (rst_i) begin
      tx_ready = 1'b0;
    end
    sdo_o = cs_o ? 1'b0 : tx_shift_q[WORD_SIZE-1];
  end

  // Datapath: load on accept, sample MISO on SCK rise, advance MOSI on SCK
  // fall, publish the received word when the word closes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      data_rx_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        tx_shift_q <= bus.data_tx_i;
        last_q     <= bus.tx_last_i;
        bit_cnt_q  <= '0;
      end
      if (rise_evt) begin
        rx_shift_q <= {rx_shift_q[WORD_SIZE-2:0], sdi_i};
        bit_cnt_q  <= bit_cnt_q + BW'(1);
      end
      if (fall_evt) begin
        tx_shift_q <= {tx_shift_q[WORD_SIZE-2:0], 1'b0};
      end
      if (end_evt) begin
        data_rx_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign bus.tx_ready_o = tx_ready;
  assign bus.busy_o     = busy;
  assign bus.data_rx_o  = data_rx_q;
  assign bus.rx_valid_o = rx_valid_q;

endmodule
